// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and default widths for the MIPS CPU memory-bus arbiter.
package mips_cpu_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   // The port that should win a tie when p was granted last.
   function automatic port_t other_port(input port_t p);
      return (p == PORT_I) ? PORT_D : PORT_I;
   endfunction

endpackage

// File: rtl/mips_cpu_arb_pick.sv
// Combinational winner selection from the two request lines and the last-granted port.
module mips_cpu_arb_pick
   import mips_cpu_bus_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_gnt,
   output logic any_req,
   output logic winner
);

   always_comb begin
      any_req = i_req | d_req;
      winner  = 1'(PORT_D);
      if (i_req && d_req) begin
         winner = 1'(other_port(port_t'(last_gnt)));
      end else if (i_req) begin
         winner = 1'(PORT_I);
      end
   end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-port (fetch / data) to single memory-bus arbiter.
// Define ARB_RR_EN for round-robin tie breaking; otherwise the data port always wins ties.
module mips_cpu_bus_arbiter #(
   parameter int unsigned ADDR_W = mips_cpu_bus_pkg::ADDR_W,
   parameter int unsigned DATA_W = mips_cpu_bus_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic                i_waitrequest,
   output logic [DATA_W-1:0]   i_readdata,

   input  logic                d_read,
   input  logic                d_write,
   input  logic [DATA_W/8-1:0] d_byteenable,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W-1:0]   d_writedata,
   output logic                d_waitrequest,
   output logic [DATA_W-1:0]   d_readdata,

   output logic                m_read,
   output logic                m_write,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W-1:0]   m_writedata,
   input  logic                m_waitrequest,
   input  logic [DATA_W-1:0]   m_readdata
);

   import mips_cpu_bus_pkg::*;

   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_t state;
   logic       last_gnt;
   logic       any_req;
   logic       winner;
   logic       done;

   // A grant ends in the cycle the memory bus stops stalling.
   assign done = (state != IDLE) && !m_waitrequest;

   mips_cpu_arb_pick u_pick (
      .i_req    (i_read),
      .d_req    (d_read | d_write),
      .last_gnt (last_gnt),
      .any_req  (any_req),
      .winner   (winner)
   );

`ifdef ARB_RR_EN
   // Starts at the data port so the fetch port takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'(PORT_D);
      end else if (done) begin
         last_gnt <= (state == GNT_I) ? 1'(PORT_I) : 1'(PORT_D);
      end
   end
`else
   // Pretending the fetch port always went last hands every tie to the data port.
   assign last_gnt = 1'(PORT_I);
`endif

   // Grant FSM; a grant is held until completion even if the request drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= (winner == 1'(PORT_D)) ? GNT_D : GNT_I;
               end
            end
            GNT_I, GNT_D: begin
               if (!m_waitrequest) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus steering and stall generation from the current grant.
   always_comb begin
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_byteenable  = '0;
      m_address     = '0;
      m_writedata   = '0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      case (state)
         GNT_I: begin
            m_read        = 1'b1;
            m_byteenable  = {BE_W{1'b1}};
            m_address     = i_address;
            i_waitrequest = m_waitrequest;
         end
         GNT_D: begin
            // A simultaneous read and write is treated as a write.
            m_write       = d_write;
            m_read        = d_read & ~d_write;
            m_byteenable  = d_byteenable;
            m_address     = d_address;
            m_writedata   = d_writedata;
            d_waitrequest = m_waitrequest;
         end
         default: begin
         end
      endcase
   end

   assign i_readdata = m_readdata;
   assign d_readdata = m_readdata;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Randomized and directed checks of mips_cpu_bus_arbiter against a transaction-level model.
module tb_mips_cpu_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_read = 1'b0;
   logic [31:0] i_address = '0;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [3:0]  d_byteenable = '0;
   logic [31:0] d_address = '0;
   logic [31:0] d_writedata = '0;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic        m_read;
   logic        m_write;
   logic [3:0]  m_byteenable;
   logic [31:0] m_address;
   logic [31:0] m_writedata;
   logic        m_waitrequest = 1'b1;
   logic [31:0] m_readdata = '0;

   always #5 clk = ~clk;

   mips_cpu_bus_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_waitrequest (i_waitrequest),
      .i_readdata    (i_readdata),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_byteenable  (d_byteenable),
      .d_address     (d_address),
      .d_writedata   (d_writedata),
      .d_waitrequest (d_waitrequest),
      .d_readdata    (d_readdata),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_byteenable  (m_byteenable),
      .m_address     (m_address),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: who owns the bus (0 nobody, 1 fetch, 2 data) and who owned it last.
   int owner = 0;
   int last  = 2;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_check();
      logic       er, ew, eiw, edw;
      logic [3:0] ebe;
      logic [31:0] ea, ed;
      er = 1'b0; ew = 1'b0; ebe = '0; ea = '0; ed = '0;
      if (owner == 1) begin
         er = 1'b1; ebe = 4'hF; ea = i_address;
      end else if (owner == 2) begin
         ew = d_write; er = d_read && !d_write;
         ebe = d_byteenable; ea = d_address; ed = d_writedata;
      end
      eiw = !(owner == 1 && !m_waitrequest);
      edw = !(owner == 2 && !m_waitrequest);
      chk("m_ctl", 64'({m_read, m_write, m_byteenable}), 64'({er, ew, ebe}));
      chk("m_address", 64'(m_address), 64'(ea));
      chk("m_writedata", 64'(m_writedata), 64'(ed));
      chk("waitrequests", 64'({i_waitrequest, d_waitrequest}), 64'({eiw, edw}));
      if (owner == 1 && !m_waitrequest) chk("i_readdata", 64'(i_readdata), 64'(m_readdata));
      if (owner == 2 && !m_waitrequest) chk("d_readdata", 64'(d_readdata), 64'(m_readdata));
   endtask

   // Ownership after the coming clock edge.
   task automatic model_advance();
      bit ri, rd;
      ri = i_read;
      rd = d_read || d_write;
      if (owner != 0) begin
         if (!m_waitrequest) begin
            last  = owner;
            owner = 0;
         end
      end else if (ri && rd) begin
         owner = RR ? ((last == 2) ? 1 : 2) : 2;
      end else if (rd) begin
         owner = 2;
      end else if (ri) begin
         owner = 1;
      end
   endtask

   task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] dwd,
                         input logic mw, input logic [31:0] mrd);
      i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_byteenable = be;
      d_address = da; d_writedata = dwd; m_waitrequest = mw; m_readdata = mrd;
   endtask

   task automatic step_begin();
      #1;
      model_check();
   endtask

   task automatic step_end();
      model_advance();
      @(negedge clk);
   endtask

   int seq [4];
   int ng;

   initial begin
      // Requests pending during reset must not reach the bus.
      set_in(1'b1, 32'h10, 1'b0, 1'b1, 4'hF, 32'h20, 32'h1234, 1'b0, 32'h0);
      @(negedge clk);
      step_begin();
      chk("reset_strobes", 64'({m_read, m_write}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous ties: observe which port completes each grant.
      ng = 0;
      for (int k = 0; k < 4; k++) seq[k] = 0;
      for (int c = 0; c < 8; c++) begin
         set_in(1'b1, 32'h200 + 32'(c), 1'b0, 1'b1, 4'h5, 32'h300, 32'hA5A5_0000 + 32'(c), 1'b0, 32'h0);
         step_begin();
         if (ng < 4 && !i_waitrequest) begin seq[ng] = 1; ng++; end
         else if (ng < 4 && !d_waitrequest) begin seq[ng] = 2; ng++; end
         step_end();
      end
      for (int k = 0; k < 4; k++) chk($sformatf("tie_order%0d", k), 64'(seq[k]),
                                      64'(RR ? ((k % 2 == 0) ? 1 : 2) : 2));
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      step_begin(); step_end();

      // Fetch and data write requested together.
      set_in(1'b1, 32'h40, 1'b0, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
      step_begin(); step_end();
      step_begin();
`ifndef ARB_RR_EN
      chk("tie_d_write", 64'({m_write, m_byteenable, d_waitrequest, i_waitrequest}),
          64'({1'b1, 4'b0011, 1'b0, 1'b1}));
      chk("tie_d_addr", 64'(m_address), 64'(32'h100));
`endif
      step_end();
      d_write = 1'b0;
      step_begin(); step_end();
      step_begin();
`ifndef ARB_RR_EN
      chk("tie_i_done", 64'(i_waitrequest), 64'(0));
`endif
      step_end();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      step_begin(); step_end();

      // Single fetch with no memory stall.
      set_in(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h8C220004);
      step_begin();
      chk("fetch_c0_wait", 64'(i_waitrequest), 64'(1));
      step_end();
      step_begin();
      chk("fetch_c1_bus", 64'({m_read, m_byteenable, m_address}), 64'({1'b1, 4'hF, 32'h40}));
      chk("fetch_c1_done", 64'({i_waitrequest, i_readdata}), 64'({1'b0, 32'h8C220004}));
      step_end();
      i_read = 1'b0;
      step_begin(); step_end();

      // Data read stalled three cycles while a fetch waits.
      set_in(1'b0, 32'h80, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b1, 32'h77);
      step_begin(); step_end();
      i_read = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step_begin();
         chk("stall_waits", 64'({d_waitrequest, i_waitrequest}), 64'(2'b11));
         step_end();
      end
      m_waitrequest = 1'b0;
      step_begin();
      chk("stall_done", 64'({d_waitrequest, i_waitrequest, d_readdata}), 64'({2'b01, 32'h77}));
      step_end();
      d_read = 1'b0;
      step_begin(); step_end();
      i_read = 1'b0;
      step_begin(); step_end();

      // Read and write together forward as a write.
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 4'hC, 32'h500, 32'h55AA, 1'b0, 32'h0);
      step_begin(); step_end();
      step_begin();
      chk("rw_both", 64'({m_write, m_read}), 64'(2'b10));
      step_end();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      step_begin(); step_end();

      // Reset during a stalled data write abandons it.
      set_in(1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h600, 32'h1111, 1'b1, 32'h0);
      step_begin(); step_end();
      step_begin();
      chk("pre_reset_write", 64'(m_write), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("reset_abort", 64'({m_write, m_read}), 64'(0));
      owner = 0;
      last  = 2;
      @(negedge clk);
      rst_n = 1'b1;
      step_begin();
      chk("post_reset_idle", 64'({m_write, d_waitrequest}), 64'(2'b01));
      step_end();

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         set_in(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom), 32'($urandom),
                1'($urandom_range(0, 2) == 0), 32'($urandom));
         step_begin();
         step_end();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of all ports.
REQ-002 Parameter: DATA_W, default 32, data width of all ports; byteenable width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_read  input  1  instruction-fetch read request.
REQ-006 i_address  input  ADDR_W  instruction-fetch address.
REQ-007 i_waitrequest  output  1  fetch stall; low only in the completion cycle.
REQ-008 i_readdata  output  DATA_W  fetch read data.
REQ-009 d_read  input  1  data-port read request.
REQ-010 d_write  input  1  data-port write request.
REQ-011 d_byteenable  input  DATA_W/8  data-port byte lanes.
REQ-012 d_address  input  ADDR_W  data-port address.
REQ-013 d_writedata  input  DATA_W  data-port write data.
REQ-014 d_waitrequest  output  1  data-port stall; low only in the completion cycle.
REQ-015 d_readdata  output  DATA_W  data-port read data.
REQ-016 m_read, m_write  output  1 each  memory-bus strobes.
REQ-017 m_byteenable, m_address, m_writedata  output  DATA_W/8, ADDR_W, DATA_W  memory-bus qualifiers.
REQ-018 m_waitrequest  input  1  memory-bus stall.
REQ-019 m_readdata  input  DATA_W  memory-bus read data.

Function
REQ-020 The FSM SHALL have three states: IDLE, GNT_I, GNT_D.
REQ-021 In IDLE: all m_* outputs SHALL be 0; both waitrequests SHALL be high whenever the matching request is asserted.
REQ-022 In IDLE: at posedge, a pending request SHALL move the FSM to the winner's grant state; with no request it SHALL stay in IDLE.
REQ-023 Simultaneous requests without ARB_RR_EN: the data port SHALL win.
REQ-024 In GNT_I: m_read=1, m_write=0, m_byteenable=all ones, m_address=i_address, m_writedata=0.
REQ-025 In GNT_D: m_read, m_write, m_byteenable, m_address and m_writedata SHALL follow the d_* inputs.
REQ-026 If d_read and d_write are both high, m_write SHALL be forwarded and m_read forced to 0.
REQ-027 Completion: the cycle in a grant state where m_waitrequest=0.
- Granted port's waitrequest SHALL be 0 in that cycle only (combinational from m_waitrequest).
- FSM SHALL return to IDLE at the next posedge.
REQ-028 i_readdata and d_readdata SHALL both be driven combinationally from m_readdata; data is valid only in the owner's completion cycle.
REQ-029 The non-granted port's waitrequest SHALL stay high for its whole wait.
REQ-030 Minimum latency: request at cycle 0, earliest completion at cycle 1; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-031 A request dropped during its grant is illegal; the grant SHALL be held until completion regardless.
REQ-032 An unbounded m_waitrequest SHALL hold the grant indefinitely, with no timeout.

Reset
REQ-033 Assertion of rst_n low SHALL immediately force IDLE and m_read=m_write=0, including mid-transaction; the interrupted transaction is abandoned.
REQ-034 With ARB_RR_EN, reset SHALL set last-granted to the data port, so the instruction port wins the first tie.

Configuration
REQ-035 Macro ARB_RR_EN defined: ties in IDLE SHALL go to the port not granted last, using a 1-bit last-granted register updated on each completion.
REQ-036 Macro ARB_RR_EN undefined: fixed data-over-instruction priority; no last-granted register is built.

Structure
REQ-037 Package mips_cpu_bus_pkg SHALL hold:
- the FSM state enum (IDLE, GNT_I, GNT_D);
- the port-id typedef (PORT_I, PORT_D);
- the constants ADDR_W and DATA_W.
REQ-038 Sub-module mips_cpu_arb_pick SHALL map requests plus last-granted to a winner, combinationally.

Verification
REQ-039 Single fetch: i_read=1 at 0x00000040, m_waitrequest=0, m_readdata=0x8C220004 -> m_read high in cycle 1 with m_byteenable=4'b1111; i_waitrequest low in cycle 1; i_readdata=0x8C220004.
REQ-040 Tie, fixed priority: i_read=1 and d_write=1 (0x100, 0xDEADBEEF, be 4'b0011) together -> data granted first, m_write=1 with be 4'b0011; fetch completes two cycles later.
REQ-041 Tie, ARB_RR_EN: repeated ties after reset -> grants alternate I, D, I, D.
REQ-042 Stall: grant held while m_waitrequest is high for 3 cycles -> requester waitrequest high for 3 cycles, low on the 4th; the other port stays stalled throughout.
REQ-043 Reset mid-transaction: rst_n low during GNT_D with m_waitrequest high -> m_write=0 immediately; after release, FSM in IDLE.
REQ-044 d_read and d_write both high -> m_write=1, m_read=0.
